// File: rtl/srcnn_frame_sequencer_if.sv
// Stream bundle between the input DMA, the SRCNN core ports and the output DMA.
// slave is the sequencer's view; master is the surrounding environment's view.
interface srcnn_frame_sequencer_if #(
  parameter int unsigned DataWidth = 48
);
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [DataWidth-1:0] s_data_i;
  logic                 s_user_i;
  logic                 s_last_i;
  logic                 core_valid_o;
  logic                 core_ready_i;
  logic [DataWidth-1:0] core_data_o;
  logic                 core_m_valid_i;
  logic                 core_m_ready_o;
  logic [DataWidth-1:0] core_m_data_i;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic [DataWidth-1:0] m_data_o;
  logic                 m_user_o;
  logic                 m_last_o;

  modport slave (
    input  s_valid_i, s_data_i, s_user_i, s_last_i,
    input  core_ready_i, core_m_valid_i, core_m_data_i, m_ready_i,
    output s_ready_o, core_valid_o, core_data_o, core_m_ready_o,
    output m_valid_o, m_data_o, m_user_o, m_last_o
  );

  modport master (
    output s_valid_i, s_data_i, s_user_i, s_last_i,
    output core_ready_i, core_m_valid_i, core_m_data_i, m_ready_i,
    input  s_ready_o, core_valid_o, core_data_o, core_m_ready_o,
    input  m_valid_o, m_data_o, m_user_o, m_last_o
  );
endinterface

// File: rtl/srcnn_frame_sequencer.sv
// Frame controller around the SRCNN core: admits Height*Width input pixels per start,
// counts output pixels, tags SOF/EOL and reports done, framing errors and frame count.
module srcnn_frame_sequencer #(
  parameter int unsigned DataWidth = 48,
  parameter int unsigned Height    = 480,
  parameter int unsigned Width     = 640
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] frame_count_o,
  srcnn_frame_sequencer_if.slave bus
);
  // Single-column/row frames still need a 1-bit counter to stay legal.
  localparam int unsigned XW = (Width  > 1) ? $clog2(Width)  : 1;
  localparam int unsigned YW = (Height > 1) ? $clog2(Height) : 1;
  localparam logic [XW-1:0] XLast = XW'(Width - 1);
  localparam logic [YW-1:0] YLast = YW'(Height - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] in_x_q, in_x_d, out_x_q, out_x_d;
  logic [YW-1:0] in_y_q, in_y_d, out_y_q, out_y_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic in_en, out_en, in_hs, out_hs, in_end, out_end, frame_err;

  always_comb begin
    in_en  = (state_q == RUN);
    out_en = (state_q == RUN) || (state_q == DRAIN);

    bus.core_valid_o   = bus.s_valid_i & in_en;
    bus.s_ready_o      = bus.core_ready_i & in_en;
    bus.core_data_o    = bus.s_data_i[DataWidth-1:0];
    bus.m_valid_o      = bus.core_m_valid_i & out_en;
    bus.core_m_ready_o = bus.m_ready_i & out_en;
    bus.m_data_o       = bus.core_m_data_i;
    bus.m_user_o       = (out_x_q == '0) && (out_y_q == '0);
    bus.m_last_o       = (out_x_q == XLast);

    in_hs     = bus.s_valid_i & bus.core_ready_i & in_en;
    out_hs    = bus.core_m_valid_i & bus.m_ready_i & out_en;
    in_end    = (in_x_q == XLast) && (in_y_q == YLast);
    out_end   = (out_x_q == XLast) && (out_y_q == YLast);
    frame_err = (bus.s_last_i != (in_x_q == XLast)) ||
                (bus.s_user_i != ((in_x_q == '0) && (in_y_q == '0)));
  end

  always_comb begin
    state_d       = state_q;
    in_x_d        = in_x_q;
    in_y_d        = in_y_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    done_d        = 1'b0;
    err_d         = err_q;
    frame_count_d = frame_count_q;

    if (in_hs) begin
      if (in_x_q == XLast) begin
        in_x_d = '0;
        in_y_d = (in_y_q == YLast) ? '0 : in_y_q + 1'b1;
      end else begin
        in_x_d = in_x_q + 1'b1;
      end
      if (frame_err) err_d = 1'b1;
    end

    if (out_hs) begin
      if (out_x_q == XLast) begin
        out_x_d = '0;
        out_y_d = (out_y_q == YLast) ? '0 : out_y_q + 1'b1;
      end else begin
        out_x_d = out_x_q + 1'b1;
      end
    end

    // Last input and last output may land together in RUN; skip DRAIN then.
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          in_x_d  = '0;
          in_y_d  = '0;
          out_x_d = '0;
          out_y_d = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (in_hs && in_end) begin
          if (out_hs && out_end) begin
            state_d       = IDLE;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_hs && out_end) begin
          state_d       = IDLE;
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      in_x_q        <= '0;
      in_y_q        <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      in_x_q        <= in_x_d;
      in_y_q        <= in_y_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      done_q        <= done_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    busy_o        = (state_q != IDLE);
    done_o        = done_q;
    err_o         = err_q;
    frame_count_o = frame_count_q;
  end
endmodule

// File: tb/tb_srcnn_frame_sequencer.sv
// Bench for srcnn_frame_sequencer: 4x3 frames against a pixel-count model with an echo core,
// plus a 1x1 instance with the core looped back combinationally.
module tb_srcnn_frame_sequencer;
  localparam int H  = 4;
  localparam int W  = 3;
  localparam int N  = H * W;
  localparam int DW = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [15:0] fc;
  logic        start2 = 1'b0;
  logic        busy2, done2, err2;
  logic [15:0] fc2;

  srcnn_frame_sequencer_if #(.DataWidth(DW)) bus ();
  srcnn_frame_sequencer_if #(.DataWidth(DW)) if2 ();

  srcnn_frame_sequencer #(.DataWidth(DW), .Height(H), .Width(W)) dut (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .err_o(err), .frame_count_o(fc), .bus(bus)
  );

  srcnn_frame_sequencer #(.DataWidth(DW), .Height(1), .Width(1)) dut2 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .err_o(err2), .frame_count_o(fc2), .bus(if2)
  );

  assign if2.core_ready_i   = if2.core_m_ready_o;
  assign if2.core_m_valid_i = if2.core_valid_o;
  assign if2.core_m_data_i  = if2.core_data_o;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is "in progress" from accepted start until N outputs have left.
  bit          busy_m, err_m, done_m;
  int          in_cnt, out_cnt;
  bit   [15:0] fc_m;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] core_q[$];

  bit            in_hs_s, out_hs_s, start_s, user_s, last_s, push_s, pop_s;
  logic [DW-1:0] data_s, cdata_s;
  bit            in_en_m;
  int            n_done, n_out;
  bit   [15:0]   last_mask, user_mask;

  always @(negedge clk) begin
    in_en_m = busy_m && (in_cnt < N);
    chk("s_ready",      bus.s_ready_o,      bus.core_ready_i & in_en_m);
    chk("core_valid",   bus.core_valid_o,   bus.s_valid_i & in_en_m);
    chk("core_data",    bus.core_data_o,    bus.s_data_i);
    chk("m_valid",      bus.m_valid_o,      bus.core_m_valid_i & busy_m);
    chk("core_m_ready", bus.core_m_ready_o, bus.m_ready_i & busy_m);
    chk("m_data_pass",  bus.m_data_o,       bus.core_m_data_i);
    chk("busy",         busy,               busy_m);
    chk("done",         done,               done_m);
    chk("err",          err,                err_m);
    chk("frame_count",  fc,                 fc_m);
    if (bus.m_valid_o && bus.m_ready_i) begin
      if (sb.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        chk("m_data", bus.m_data_o, sb[0]);
        chk("m_user", bus.m_user_o, out_cnt == 0);
        chk("m_last", bus.m_last_o, (out_cnt % W) == W - 1);
      end
      if (bus.m_user_o && out_cnt < 16) user_mask[out_cnt] = 1'b1;
      if (bus.m_last_o && out_cnt < 16) last_mask[out_cnt] = 1'b1;
      n_out++;
    end
    if (done) n_done++;
    in_hs_s  = bus.s_valid_i && bus.s_ready_o;
    out_hs_s = bus.m_valid_o && bus.m_ready_i;
    start_s  = start && !busy_m;
    user_s   = bus.s_user_i;
    last_s   = bus.s_last_i;
    data_s   = bus.s_data_i;
    push_s   = bus.core_valid_o && bus.core_ready_i;
    pop_s    = bus.core_m_valid_i && bus.core_m_ready_o;
    cdata_s  = bus.core_data_o;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0; err_m <= 1'b0; done_m <= 1'b0;
      in_cnt <= 0; out_cnt <= 0; fc_m <= '0;
      sb.delete(); core_q.delete();
      bus.core_m_valid_i <= 1'b0;
      bus.core_m_data_i  <= '0;
    end else begin
      done_m <= 1'b0;
      if (start_s) begin
        busy_m <= 1'b1; in_cnt <= 0; out_cnt <= 0; err_m <= 1'b0;
      end
      if (in_hs_s) begin
        in_cnt <= in_cnt + 1;
        sb.push_back(data_s);
        if (user_s != (in_cnt == 0) || last_s != ((in_cnt % W) == W - 1)) err_m <= 1'b1;
      end
      if (out_hs_s) begin
        if (sb.size() > 0) void'(sb.pop_front());
        if (out_cnt == N - 1) begin
          busy_m <= 1'b0; done_m <= 1'b1; fc_m <= fc_m + 16'd1; out_cnt <= 0;
        end else out_cnt <= out_cnt + 1;
      end
      if (pop_s && core_q.size() > 0) void'(core_q.pop_front());
      if (push_s) core_q.push_back(cdata_s);
      bus.core_m_valid_i <= core_q.size() > 0;
      bus.core_m_data_i  <= (core_q.size() > 0) ? core_q[0] : '0;
    end
  end

  int m_mode = 0;
  initial begin
    bus.m_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (m_mode == 1) bus.m_ready_i = 1'($urandom_range(0, 1));
      else bus.m_ready_i = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input int n, input int bad, input logic [15:0] tag, output int acc);
    acc = 0;
    for (int b = 0; b < n; b++) begin
      bit ok;
      ok = 1'b0;
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = {tag, 16'h0, 16'(b)};
      bus.s_user_i  = (b == 0);
      bus.s_last_i  = (((b % W) == W - 1) != (b == bad));
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.s_ready_o) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) break;
      acc++;
      tick();
    end
    bus.s_valid_i = 1'b0; bus.s_user_i = 1'b0; bus.s_last_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk(name, 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.s_user_i = 1'b0; bus.s_last_i = 1'b0;
    bus.core_ready_i = 1'b1;
    if2.s_valid_i = 1'b0; if2.s_data_i = '0; if2.s_user_i = 1'b0; if2.s_last_i = 1'b0;
    if2.m_ready_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_fc", fc, 0); chk("rst_s_ready", bus.s_ready_o, 0);
    tick();

    // 1: clean frame
    last_mask = '0; user_mask = '0; n_out = 0; base = n_done;
    do_start();
    send(N, -1, 16'h0001, acc);
    chk("t1_accepted", acc, N);
    wait_idle("t1_idle_timeout", 100);
    chk("t1_done", done, 1);
    chk("t1_fc", fc, 1);
    chk("t1_last_mask", last_mask, 16'h0924);
    chk("t1_user_mask", user_mask, 16'h0001);
    chk("t1_n_out", n_out, N);
    tick();
    @(negedge clk);
    chk("t1_done_width", done, 0);
    chk("t1_done_pulses", n_done - base, 1);
    tick();

    // 2: source offers more than a frame
    base = n_done;
    do_start();
    send(N + 3, -1, 16'h0002, acc);
    chk("t2_accepted", acc, N);
    chk("t2_done_pulses", n_done - base, 1);
    chk("t2_fc", fc, 2);
    chk("t2_busy", busy, 0);
    tick();

    // 3: bad EOL on beat 2; start in the done cycle clears err
    do_start();
    send(N, 1, 16'h0003, acc);
    @(negedge clk);
    chk("t3_err_set", err, 1);
    wait_idle("t3_idle_timeout", 100);
    chk("t3_done", done, 1);
    chk("t3_err_at_done", err, 1);
    do_start();
    @(negedge clk);
    chk("t3_err_cleared", err, 0);
    chk("t3_busy_restart", busy, 1);
    tick();
    send(N, -1, 16'h0013, acc);
    wait_idle("t3b_idle_timeout", 100);
    chk("t3_fc", fc, 4);
    tick();

    // 4: random output back-pressure
    m_mode = 1; n_out = 0;
    do_start();
    send(N, -1, 16'h0004, acc);
    wait_idle("t4_idle_timeout", 400);
    m_mode = 0;
    chk("t4_n_out", n_out, N);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_fc", fc, 5);
    tick();

    // 5: start pulse in RUN, then reset mid-frame
    do_start();
    start = 1'b1; tick(); start = 1'b0;
    send(7, -1, 16'h0005, acc);
    chk("t5_accepted", acc, 7);
    chk("t5_err_clean", err, 0);
    bus.s_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0); chk("t5_rst_done", done, 0); chk("t5_rst_err", err, 0);
    chk("t5_rst_fc", fc, 0); chk("t5_rst_s_ready", bus.s_ready_o, 0);
    chk("t5_rst_core_valid", bus.core_valid_o, 0); chk("t5_rst_m_valid", bus.m_valid_o, 0);
    chk("t5_rst_core_m_ready", bus.core_m_ready_o, 0);
    tick();
    bus.s_valid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    do_start();
    send(N, -1, 16'h0015, acc);
    wait_idle("t5_idle_timeout", 100);
    chk("t5_done", done, 1);
    chk("t5_fc", fc, 1);
    tick();

    // 6: 1x1 frame with combinational core loop-back
    start2 = 1'b1; tick(); start2 = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy2, 1);
    @(posedge clk); #1;
    if2.s_valid_i = 1'b1; if2.s_user_i = 1'b1; if2.s_last_i = 1'b1;
    if2.s_data_i = 48'h1234_5678_9ABC;
    @(negedge clk);
    chk("t6_s_ready", if2.s_ready_o, 1);
    chk("t6_m_valid", if2.m_valid_o, 1);
    chk("t6_m_user", if2.m_user_o, 1);
    chk("t6_m_last", if2.m_last_o, 1);
    chk("t6_m_data", if2.m_data_o, 48'h1234_5678_9ABC);
    @(posedge clk); #1;
    if2.s_valid_i = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    chk("t6_done", done2, 1); chk("t6_idle", busy2, 0);
    chk("t6_fc", fc2, 1); chk("t6_err", err2, 0);
    tick();
    start2 = 1'b0;
    @(negedge clk);
    chk("t6_b2b_busy", busy2, 1);
    chk("t6_b2b_done_low", done2, 0);
    @(posedge clk); #1;
    if2.s_valid_i = 1'b1; if2.s_data_i = 48'h0000_0000_0042;
    tick();
    if2.s_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_done2", done2, 1);
    chk("t6_fc2", fc2, 2);
    chk("t6_err2", err2, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
